adc_avg_scale: RTL and testbench



---
 rtl/adc_avg_scale.sv | 194 +++++++++++++++++++
 tb/tb_adc_avg_scale.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_avg_scale.sv
// adc_avg_scale
// -------------
// Conditioning stage between the ADC0809 sequencing controller and the
// 4-digit FND driver. Accepts 2^AVG_LOG2 conversion results, takes their
// truncated average, scales it to 0..1000 with a sequential restoring
// divider (divide by 255), and converts the scaled value to packed BCD with
// a sequential double-dabble. The final value is presented on registered
// outputs together with a one-cycle done strobe.
//
// Ports
//   clk           system clock, all state updates on the rising edge
//   reset         asynchronous, active-low reset
//   sample_valid  one-cycle strobe, result holds a new conversion code
//   result        ADC conversion code 0..255
//   busy          high while a computation is in flight (state != IDLE)
//   num           scaled value 0..1000, binary, held between done pulses
//   bcd           packed BCD of num: [15:12] thousands .. [3:0] units
//   done          one-cycle pulse, num/bcd updated on this cycle
//   overrun       one-cycle pulse, a sample was dropped because busy
//   state_dbg     current FSM state (0 IDLE, 1 MUL, 2 DIV, 3 BCD, 4 DONE)
//
// Handshake: sample_valid is a single-cycle strobe with no back-pressure.
// A strobe seen while state is IDLE is accepted; a strobe seen in any other
// state is discarded and reported one cycle later on overrun.
//
// Latency, with E0 the edge that accepts the last sample of a group:
//   E1 MUL->DIV, E2..E19 divide steps, E20..E29 dabble steps,
//   E30 num/bcd load and done rises, E31 done falls and a new sample
//   can be accepted.

module adc_avg_scale #(
  parameter int AVG_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [7:0]  result,
  output logic        busy,
  output logic [9:0]  num,
  output logic [15:0] bcd,
  output logic        done,
  output logic        overrun,
  output logic [2:0]  state_dbg
);

  // Accumulator wide enough for 2^AVG_LOG2 samples of 255.
  localparam int AW = 8 + AVG_LOG2;
  // The sample counter needs at least one bit even when a group is a
  // single sample; in that case it simply stays at zero.
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int NS = 1 << AVG_LOG2;
  localparam logic [CW-1:0] CNT_LAST = CW'(NS - 1);

  localparam logic [4:0] DIV_LAST = 5'd17;  // 18 quotient bits
  localparam logic [4:0] BCD_LAST = 5'd9;   // 10 binary bits to shift out

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_BCD  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  // prod holds the dividend at the start of DIV; quotient bits are shifted
  // in at the bottom as dividend bits leave at the top, so after 18 steps
  // it holds the quotient (which fits in its low 10 bits).
  logic [17:0]   prod;
  logic [8:0]    rem;
  logic [4:0]    step;
  logic [9:0]    dab_bin;
  logic [15:0]   dab_bcd;

  // ---------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------
  logic [7:0]  avg;
  logic [17:0] prod_mul;
  logic [8:0]  rem_sh;
  logic        rem_ge;
  logic [8:0]  rem_nx;
  logic [17:0] prod_nx;
  logic [15:0] bcd_adj;

  // Truncating average; the upper bits of the shifted accumulator are
  // always zero for a full group.
  assign avg      = 8'(acc >> AVG_LOG2);
  assign prod_mul = 18'(avg) * 18'd1000;

  // One restoring division step: bring down the next dividend bit, and
  // subtract the divisor when it fits.
  assign rem_sh  = {rem[7:0], prod[17]};
  assign rem_ge  = (rem_sh >= 9'd255);
  assign rem_nx  = rem_ge ? (rem_sh - 9'd255) : rem_sh;
  assign prod_nx = {prod[16:0], rem_ge};

  function automatic logic [3:0] dabble_adj(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // Every nibble >= 5 is corrected before the shift so that the doubling
  // carries into the next decimal digit.
  assign bcd_adj = {dabble_adj(dab_bcd[15:12]), dabble_adj(dab_bcd[11:8]),
                    dabble_adj(dab_bcd[7:4]),   dabble_adj(dab_bcd[3:0])};

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // ---------------------------------------------------------------------
  // Control FSM and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      acc     <= '0;
      cnt     <= '0;
      prod    <= '0;
      rem     <= '0;
      step    <= '0;
      dab_bin <= '0;
      dab_bcd <= '0;
      num     <= '0;
      bcd     <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done    <= 1'b0;
      // Any strobe outside IDLE, including the DONE cycle, is dropped.
      overrun <= sample_valid && (state != S_IDLE);

      case (state)
        S_IDLE: begin
          if (sample_valid) begin
            acc <= acc + AW'(result);
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= S_MUL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        S_MUL: begin
          prod  <= prod_mul;
          acc   <= '0;
          rem   <= '0;
          step  <= '0;
          state <= S_DIV;
        end

        S_DIV: begin
          rem  <= rem_nx;
          prod <= prod_nx;
          if (step == DIV_LAST) begin
            step    <= '0;
            dab_bin <= prod_nx[9:0];
            dab_bcd <= '0;
            state   <= S_BCD;
          end else begin
            step <= step + 5'd1;
          end
        end

        S_BCD: begin
          dab_bcd <= {bcd_adj[14:0], dab_bin[9]};
          dab_bin <= {dab_bin[8:0], 1'b0};
          if (step == BCD_LAST) begin
            step  <= '0;
            state <= S_DONE;
          end else begin
            step <= step + 5'd1;
          end
        end

        S_DONE: begin
          // prod still holds the quotient; dab_bcd holds its BCD image.
          num   <= prod[9:0];
          bcd   <= dab_bcd;
          done  <= 1'b1;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_avg_scale.sv
// Testbench for adc_avg_scale: one instance with AVG_LOG2=2 and one with
// AVG_LOG2=0, a behavioural reference model, a per-cycle compare process,
// directed stimulus with literal expectations, and a final report.

module tb_adc_avg_scale;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------
  logic        sv0 = 1'b0;
  logic [7:0]  res0 = 8'd0;
  logic        busy0, done0, ovr0;
  logic [9:0]  num0;
  logic [15:0] bcd0;
  logic [2:0]  st0;

  logic        sv1 = 1'b0;
  logic [7:0]  res1 = 8'd0;
  logic        busy1, done1, ovr1;
  logic [9:0]  num1;
  logic [15:0] bcd1;
  logic [2:0]  st1;

  adc_avg_scale #(.AVG_LOG2(2)) dut0 (
    .clk(clk), .reset(reset), .sample_valid(sv0), .result(res0),
    .busy(busy0), .num(num0), .bcd(bcd0), .done(done0), .overrun(ovr0),
    .state_dbg(st0)
  );

  adc_avg_scale #(.AVG_LOG2(0)) dut1 (
    .clk(clk), .reset(reset), .sample_valid(sv1), .result(res1),
    .busy(busy1), .num(num1), .bcd(bcd1), .done(done1), .overrun(ovr1),
    .state_dbg(st1)
  );

  // ---------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: a group of N samples is averaged by integer division,
  // scaled as avg*1000/255, and reported 30 edges after the group's last
  // sample. Strobes during those 30 edges are dropped and flagged.
  // ---------------------------------------------------------------------
  logic [7:0]  grp_q0[$];
  logic [7:0]  grp_q1[$];
  int          m_busy[2];
  int          m_pend[2];
  logic        e_busy[2];
  logic        e_done[2];
  logic        e_ovr[2];
  logic [9:0]  e_num[2];
  logic [15:0] e_bcd[2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0; m_pend[d] = 0; e_busy[d] = 0; e_done[d] = 0;
      e_ovr[d] = 0; e_num[d] = '0; e_bcd[d] = '0;
    end
  end

  function automatic logic [15:0] to_bcd(input int v);
    logic [3:0] th, hu, te, un;
    th = 4'(v / 1000);
    hu = 4'((v / 100) % 10);
    te = 4'((v / 10) % 10);
    un = 4'(v % 10);
    return {th, hu, te, un};
  endfunction

  function automatic int scale_group(input int sum, input int n);
    return ((sum / n) * 1000) / 255;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      grp_q0.delete();
      grp_q1.delete();
      for (int d = 0; d < 2; d++) begin
        m_busy[d] = 0; m_pend[d] = 0; e_busy[d] = 0; e_done[d] = 0;
        e_ovr[d] = 0; e_num[d] = '0; e_bcd[d] = '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        logic       sv;
        logic [7:0] r;
        int         sum;
        sv = (d == 0) ? sv0 : sv1;
        r  = (d == 0) ? res0 : res1;
        e_done[d] = 1'b0;
        e_ovr[d]  = 1'b0;
        if (m_busy[d] > 0) begin
          m_busy[d]--;
          if (sv) e_ovr[d] = 1'b1;
          if (m_busy[d] == 0) begin
            e_done[d] = 1'b1;
            e_num[d]  = 10'(m_pend[d]);
            e_bcd[d]  = to_bcd(m_pend[d]);
          end
        end else if (sv) begin
          if (d == 0) begin
            grp_q0.push_back(r);
            if (grp_q0.size() == 4) begin
              sum = 0;
              foreach (grp_q0[i]) sum += grp_q0[i];
              m_pend[0] = scale_group(sum, 4);
              m_busy[0] = 30;
              grp_q0.delete();
            end
          end else begin
            grp_q1.push_back(r);
            m_pend[1] = scale_group(int'(grp_q1[0]), 1);
            m_busy[1] = 30;
            grp_q1.delete();
          end
        end
        e_busy[d] = (m_busy[d] > 0);
      end
    end
  end

  // Compare process: every falling edge, all outputs of both instances.
  always @(negedge clk) begin
    chk("cyc0_busy",    32'(busy0), 32'(e_busy[0]));
    chk("cyc0_done",    32'(done0), 32'(e_done[0]));
    chk("cyc0_overrun", 32'(ovr0),  32'(e_ovr[0]));
    chk("cyc0_num",     32'(num0),  32'(e_num[0]));
    chk("cyc0_bcd",     32'(bcd0),  32'(e_bcd[0]));
    chk("cyc1_busy",    32'(busy1), 32'(e_busy[1]));
    chk("cyc1_done",    32'(done1), 32'(e_done[1]));
    chk("cyc1_overrun", 32'(ovr1),  32'(e_ovr[1]));
    chk("cyc1_num",     32'(num1),  32'(e_num[1]));
    chk("cyc1_bcd",     32'(bcd1),  32'(e_bcd[1]));
  end

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  // Presents one sample for exactly one rising edge; returns on the
  // falling edge right after the accepting edge.
  task automatic send(input int d, input logic [7:0] v);
    @(negedge clk);
    if (d == 0) begin sv0 = 1'b1; res0 = v; end
    else        begin sv1 = 1'b1; res1 = v; end
    @(negedge clk);
    sv0 = 1'b0;
    sv1 = 1'b0;
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] e);
    send(0, a); send(0, b); send(0, c); send(0, e);
  endtask

  function automatic logic dn(input int d);
    return (d == 0) ? done0 : done1;
  endfunction

  function automatic logic bz(input int d);
    return (d == 0) ? busy0 : busy1;
  endfunction

  // Waits (bounded) for done, counting falling edges on which busy was high.
  task automatic wait_done(input int d, output int busy_cycles);
    logic seen;
    seen = 1'b0;
    busy_cycles = 0;
    for (int t = 0; t < 100; t++) begin
      if (dn(d)) begin
        seen = 1'b1;
        break;
      end
      if (bz(d)) busy_cycles++;
      @(negedge clk);
    end
    chk("done_within_budget", 32'(seen), 32'd1);
  endtask

  task automatic check_group0(input string tag, input logic [9:0] n,
                              input logic [15:0] b);
    int bc;
    wait_done(0, bc);
    chk({tag, "_busy_cycles"}, 32'(bc), 32'd30);
    chk({tag, "_num"}, 32'(num0), 32'(n));
    chk({tag, "_bcd"}, 32'(bcd0), 32'(b));
    @(negedge clk);
    chk({tag, "_done_fall"}, 32'(done0), 32'd0);
    chk({tag, "_num_hold"}, 32'(num0), 32'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_num"},     32'(num0),  32'd0);
    chk({tag, "_bcd"},     32'(bcd0),  32'd0);
    chk({tag, "_done"},    32'(done0), 32'd0);
    chk({tag, "_overrun"}, 32'(ovr0),  32'd0);
    chk({tag, "_busy"},    32'(busy0), 32'd0);
    chk({tag, "_state"},   32'(st0),   32'd0);
  endtask

  // ---------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------
  initial begin
    int bc;

    #1 reset = 1'b0;
    #1 check_reset_outputs("reset_init");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Full scale
    send4(8'd255, 8'd255, 8'd255, 8'd255);
    check_group0("full", 10'd1000, 16'h1000);

    // Mid scale: 128000/255 = 501.96
    send4(8'd128, 8'd128, 8'd128, 8'd128);
    check_group0("mid", 10'd501, 16'h0501);

    // Averaging truncation: 406/4 = 101, 101000/255 = 396.07
    send4(8'd100, 8'd101, 8'd102, 8'd103);
    check_group0("trunc", 10'd396, 16'h0396);

    // 3/4 truncates to 0
    send4(8'd0, 8'd0, 8'd0, 8'd3);
    check_group0("zero", 10'd0, 16'h0000);

    // Overrun: group of 200 -> 784; strobes at E5 and E30 are dropped
    send4(8'd200, 8'd200, 8'd200, 8'd200);      // now at the fall after E0
    repeat (4) @(negedge clk);                  // fall after E4
    sv0 = 1'b1; res0 = 8'd250;
    @(negedge clk);                             // fall after E5
    sv0 = 1'b0;
    chk("ovr_e5_pulse", 32'(ovr0), 32'd1);
    @(negedge clk);
    chk("ovr_e5_width", 32'(ovr0), 32'd0);
    repeat (23) @(negedge clk);                 // fall after E29
    sv0 = 1'b1; res0 = 8'd250;
    @(negedge clk);                             // fall after E30
    sv0 = 1'b0;
    chk("ovr_e30_done", 32'(done0), 32'd1);
    chk("ovr_e30_pulse", 32'(ovr0), 32'd1);
    chk("ovr_num", 32'(num0), 32'd784);
    chk("ovr_bcd", 32'(bcd0), 32'h0784);
    @(negedge clk);
    chk("ovr_e30_width", 32'(ovr0), 32'd0);
    // Three fresh samples must not complete a group
    send(0, 8'd10); send(0, 8'd10); send(0, 8'd10);
    repeat (3) @(negedge clk);
    chk("after_ovr_idle", 32'(busy0), 32'd0);
    send(0, 8'd10);
    check_group0("after_ovr", 10'd39, 16'h0039);

    // Reset in the middle of DIV (at E12)
    send4(8'd77, 8'd77, 8'd77, 8'd77);
    repeat (11) @(negedge clk);                 // fall after E11
    @(posedge clk);                             // E12
    #1 reset = 1'b0;
    #1 check_reset_outputs("reset_div");
    @(negedge clk);
    reset = 1'b1;

    // Partial group lost across reset
    send(0, 8'd255); send(0, 8'd255);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    send4(8'd51, 8'd51, 8'd51, 8'd51);
    check_group0("after_reset", 10'd200, 16'h0200);

    // Single-sample groups: 1000/255 = 3.92, 254000/255 = 996.08
    send(1, 8'd1);
    wait_done(1, bc);
    chk("one_busy_cycles", 32'(bc), 32'd30);
    chk("one_num", 32'(num1), 32'd3);
    chk("one_bcd", 32'(bcd1), 32'h0003);
    @(negedge clk);
    send(1, 8'd254);
    wait_done(1, bc);
    chk("max1_num", 32'(num1), 32'd996);
    chk("max1_bcd", 32'(bcd1), 32'h0996);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
